sram_port_arbiter: RTL and testbench

//  Shares the single SRAM port between the pixel-read path (stage 1) and the result-write path (stage 3).

---
 rtl/detection_pkg.sv | 34 +++
 rtl/sram_port_arbiter_counter.sv | 37 +++
 rtl/sram_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/detection_pkg.sv
// Shared types and defaults for the SRAM port arbiter slice.
package detection_pkg;

    localparam int              DEF_ADDR_W  = 16;
    localparam int              DEF_DATA_W  = 32;
    localparam logic [15:0]     DEF_RD_BASE = 16'h0000;
    localparam logic [15:0]     DEF_WR_BASE = 16'h8000;

    // Arbiter FSM encoding (explicit values keep legacy-compatible codes)
    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_RD_ACC = 3'd1,
        ARB_WR_ACC = 3'd2,
        ARB_RD_CPL = 3'd3,
        ARB_WR_CPL = 3'd4
    } arb_state_t;

    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_t;

    // Direction that should win a tie after the given grant
    function automatic grant_t other_grant(input grant_t g);
        grant_t o;
        case (g)
            GNT_READ:  o = GNT_WRITE;
            GNT_WRITE: o = GNT_READ;
            default:   o = GNT_READ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_counter.sv
// Frame position counter: counts 0..LIMIT, then wraps (WRAP=1) or holds (WRAP=0).
module frame_addr_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 399,
    parameter bit WRAP  = 1'b1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_limit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_r;

    // Count register: clear wins over increment, wrap or saturate at the limit
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc) begin
            if (count_r == LIMIT_V) begin
                count_r <= WRAP ? '0 : LIMIT_V;
            end else begin
                count_r <= count_r + W'(1);
            end
        end
    end

    assign count    = count_r;
    assign at_limit = (count_r == LIMIT_V);

endmodule

// File: rtl/sram_port_arbiter.sv
// Single SRAM port shared between the pixel-read path and the result-write path.
// Requests are latched, arbitrated round-robin, held on the port for MEM_LAT
// cycles and acknowledged with one-cycle completion pulses.
module sram_port_arbiter
    import detection_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RD_BASE = ADDR_W'(DEF_RD_BASE),
    parameter logic [ADDR_W-1:0] WR_BASE = ADDR_W'(DEF_WR_BASE),
    parameter int                NUM_PIX = 400,
    parameter int                MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_frame_start,
    input  logic              i_re,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_read_complete,
    output logic              o_write_complete,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int              LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    arb_state_t        state_r, state_n;
    grant_t            last_r, last_n;
    logic [LAT_W-1:0]  lat_r, lat_n;
    logic              rd_pend_r, rd_pend_n, wr_pend_r, wr_pend_n;
    logic [DATA_W-1:0] wdata_r, wdata_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic              ren_r, ren_n, wen_r, wen_n;
    logic [DATA_W-1:0] mwdata_r, mwdata_n, rdata_r, rdata_n;
    logic              rcpl_r, rcpl_n, wcpl_r, wcpl_n;
    logic              busy_r, busy_n, done_r, done_n, err_r, err_n;

    logic              re_ok_s, we_ok_s, rd_want_s, wr_want_s, arb_en_s;
    logic              launch_rd_s, launch_wr_s;
    logic              rd_inc_s, wr_inc_s, cnt_clr_s;
    logic [ADDR_W-1:0] rd_cnt_s, wr_cnt_s;
    logic              wr_at_limit_s, rd_wrap_unused_s;

    frame_addr_counter #(.W(ADDR_W), .LIMIT(NUM_PIX - 1), .WRAP(1'b1)) u_rd_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clr_s),
        .inc      (rd_inc_s),
        .count    (rd_cnt_s),
        .at_limit (rd_wrap_unused_s)
    );

    frame_addr_counter #(.W(ADDR_W), .LIMIT(NUM_PIX - 1), .WRAP(1'b0)) u_wr_cnt (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (cnt_clr_s),
        .inc      (wr_inc_s),
        .count    (wr_cnt_s),
        .at_limit (wr_at_limit_s)
    );

    // Next-state logic: request latching, arbitration, access timing, frame restart
    always_comb begin
        state_n     = state_r;
        last_n      = last_r;
        lat_n       = lat_r;
        rd_pend_n   = rd_pend_r;
        wr_pend_n   = wr_pend_r;
        wdata_n     = wdata_r;
        addr_n      = addr_r;
        ren_n       = 1'b0;
        wen_n       = 1'b0;
        mwdata_n    = mwdata_r;
        rdata_n     = rdata_r;
        rcpl_n      = 1'b0;
        wcpl_n      = 1'b0;
        done_n      = done_r;
        err_n       = err_r;
        rd_inc_s    = 1'b0;
        wr_inc_s    = 1'b0;
        cnt_clr_s   = 1'b0;
        arb_en_s    = 1'b0;
        launch_rd_s = 1'b0;
        launch_wr_s = 1'b0;

        // A request is accepted only if its direction is free and the frame is not done
        re_ok_s = i_re & ~rd_pend_r & ~done_r;
        we_ok_s = i_we & ~wr_pend_r & ~done_r;
        if ((i_re & ~re_ok_s) | (i_we & ~we_ok_s)) begin
            err_n = 1'b1;
        end else begin
            err_n = err_r;
        end
        if (re_ok_s) begin
            rd_pend_n = 1'b1;
        end else begin
            rd_pend_n = rd_pend_r;
        end
        if (we_ok_s) begin
            wr_pend_n = 1'b1;
            wdata_n   = i_wdata;
        end else begin
            wr_pend_n = wr_pend_r;
        end

        // The direction being completed this cycle is no longer a candidate
        rd_want_s = re_ok_s | (rd_pend_r & (state_r != ARB_RD_CPL));
        wr_want_s = we_ok_s | (wr_pend_r & (state_r != ARB_WR_CPL));

        case (state_r)
            ARB_IDLE: begin
                arb_en_s = 1'b1;
            end
            ARB_RD_ACC: begin
                if (lat_r == LAT_LAST) begin
                    rdata_n = i_mem_rdata;
                    rcpl_n  = 1'b1;
                    state_n = ARB_RD_CPL;
                end else begin
                    ren_n   = 1'b1;
                    lat_n   = lat_r + LAT_W'(1);
                end
            end
            ARB_WR_ACC: begin
                if (lat_r == LAT_LAST) begin
                    wcpl_n  = 1'b1;
                    state_n = ARB_WR_CPL;
                end else begin
                    wen_n   = 1'b1;
                    lat_n   = lat_r + LAT_W'(1);
                end
            end
            ARB_RD_CPL: begin
                rd_pend_n = 1'b0;
                last_n    = GNT_READ;
                rd_inc_s  = 1'b1;
                state_n   = ARB_IDLE;
                arb_en_s  = 1'b1;
            end
            ARB_WR_CPL: begin
                wr_pend_n = 1'b0;
                last_n    = GNT_WRITE;
                wr_inc_s  = 1'b1;
                done_n    = done_r | wr_at_limit_s;
                state_n   = ARB_IDLE;
                arb_en_s  = 1'b1;
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase

        // Round-robin choice; completion states chain straight into the other direction
        if (arb_en_s) begin
            if (rd_want_s & wr_want_s) begin
                if (other_grant(last_r) == GNT_WRITE) begin
                    launch_wr_s = 1'b1;
                end else begin
                    launch_rd_s = 1'b1;
                end
            end else if (rd_want_s) begin
                launch_rd_s = 1'b1;
            end else if (wr_want_s) begin
                launch_wr_s = 1'b1;
            end else begin
                launch_rd_s = 1'b0;
            end
        end else begin
            launch_rd_s = 1'b0;
        end

        if (launch_rd_s) begin
            state_n = ARB_RD_ACC;
            lat_n   = '0;
            ren_n   = 1'b1;
            addr_n  = RD_BASE + rd_cnt_s;
        end else if (launch_wr_s) begin
            state_n  = ARB_WR_ACC;
            lat_n    = '0;
            wen_n    = 1'b1;
            addr_n   = WR_BASE + wr_cnt_s;
            mwdata_n = we_ok_s ? i_wdata : wdata_r;
        end else begin
            addr_n = addr_n;
        end

        // Frame restart aborts everything in flight; captured read data survives
        if (i_frame_start) begin
            state_n   = ARB_IDLE;
            last_n    = GNT_WRITE;
            lat_n     = '0;
            rd_pend_n = 1'b0;
            wr_pend_n = 1'b0;
            ren_n     = 1'b0;
            wen_n     = 1'b0;
            rcpl_n    = 1'b0;
            wcpl_n    = 1'b0;
            rdata_n   = rdata_r;
            done_n    = 1'b0;
            err_n     = 1'b0;
            rd_inc_s  = 1'b0;
            wr_inc_s  = 1'b0;
            cnt_clr_s = 1'b1;
        end else begin
            cnt_clr_s = 1'b0;
        end

        busy_n = (state_n != ARB_IDLE) | rd_pend_n | wr_pend_n;
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= ARB_IDLE;
            last_r    <= GNT_WRITE;
            lat_r     <= '0;
            rd_pend_r <= 1'b0;
            wr_pend_r <= 1'b0;
            wdata_r   <= '0;
            addr_r    <= '0;
            ren_r     <= 1'b0;
            wen_r     <= 1'b0;
            mwdata_r  <= '0;
            rdata_r   <= '0;
            rcpl_r    <= 1'b0;
            wcpl_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            last_r    <= last_n;
            lat_r     <= lat_n;
            rd_pend_r <= rd_pend_n;
            wr_pend_r <= wr_pend_n;
            wdata_r   <= wdata_n;
            addr_r    <= addr_n;
            ren_r     <= ren_n;
            wen_r     <= wen_n;
            mwdata_r  <= mwdata_n;
            rdata_r   <= rdata_n;
            rcpl_r    <= rcpl_n;
            wcpl_r    <= wcpl_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            err_r     <= err_n;
        end
    end

    assign o_mem_addr       = addr_r;
    assign o_mem_ren        = ren_r;
    assign o_mem_wen        = wen_r;
    assign o_mem_wdata      = mwdata_r;
    assign o_rdata          = rdata_r;
    assign o_read_complete  = rcpl_r;
    assign o_write_complete = wcpl_r;
    assign o_busy           = busy_r;
    assign o_done           = done_r;
    assign o_err            = err_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (NUM_PIX=4, MEM_LAT=2).
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        i_frame_start = 1'b0;
    logic        i_re = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_wdata = 32'h0;
    logic [31:0] i_mem_rdata = 32'h0;
    logic [15:0] o_mem_addr;
    logic        o_mem_ren, o_mem_wen;
    logic [31:0] o_mem_wdata, o_rdata;
    logic        o_read_complete, o_write_complete, o_busy, o_done, o_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    sram_port_arbiter #(.NUM_PIX(4), .MEM_LAT(2)) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_frame_start    (i_frame_start),
        .i_re             (i_re),
        .i_we             (i_we),
        .i_wdata          (i_wdata),
        .i_mem_rdata      (i_mem_rdata),
        .o_mem_addr       (o_mem_addr),
        .o_mem_ren        (o_mem_ren),
        .o_mem_wen        (o_mem_wen),
        .o_mem_wdata      (o_mem_wdata),
        .o_rdata          (o_rdata),
        .o_read_complete  (o_read_complete),
        .o_write_complete (o_write_complete),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        n_rst = 1'b0; i_frame_start = 1'b0; i_re = 1'b0; i_we = 1'b0;
        i_wdata = 32'h0; i_mem_rdata = 32'h0;
        tick(); tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        n_rst = 1'b0; i_re = 1'b0; i_we = 1'b0; i_frame_start = 1'b0;
        tick(); tick();
        total_cnt++; if ({o_mem_ren, o_mem_wen, o_read_complete, o_write_complete, o_busy, o_done, o_err} !== 7'b0) $display("FAIL reset_flags: got %b exp %b", {o_mem_ren, o_mem_wen, o_read_complete, o_write_complete, o_busy, o_done, o_err}, 7'b0); else pass_cnt++;
        total_cnt++; if (o_mem_addr !== 16'h0) $display("FAIL reset_addr: got %h exp %h", o_mem_addr, 16'h0); else pass_cnt++;
        total_cnt++; if ({o_rdata, o_mem_wdata} !== 64'h0) $display("FAIL reset_data: got %h exp %h", {o_rdata, o_mem_wdata}, 64'h0); else pass_cnt++;
        n_rst = 1'b1;
        tick();
        total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy_after: got %b exp %b", o_busy, 1'b0); else pass_cnt++;
    endtask

    task automatic test_single_read();
        apply_reset();
        i_mem_rdata = 32'hA5A5_0001; i_re = 1'b1;
        tick(); i_re = 1'b0;
        total_cnt++; if (o_mem_ren !== 1'b1) $display("FAIL t1_ren_k1: got %b exp %b", o_mem_ren, 1'b1); else pass_cnt++;
        total_cnt++; if (o_mem_addr !== 16'h0000) $display("FAIL t1_addr: got %h exp %h", o_mem_addr, 16'h0000); else pass_cnt++;
        total_cnt++; if (o_busy !== 1'b1) $display("FAIL t1_busy: got %b exp %b", o_busy, 1'b1); else pass_cnt++;
        tick();
        total_cnt++; if ({o_mem_ren, o_read_complete} !== 2'b10) $display("FAIL t1_k2: got %b exp %b", {o_mem_ren, o_read_complete}, 2'b10); else pass_cnt++;
        tick();
        total_cnt++; if ({o_mem_ren, o_read_complete} !== 2'b01) $display("FAIL t1_k3_cpl: got %b exp %b", {o_mem_ren, o_read_complete}, 2'b01); else pass_cnt++;
        total_cnt++; if (o_rdata !== 32'hA5A5_0001) $display("FAIL t1_rdata: got %h exp %h", o_rdata, 32'hA5A5_0001); else pass_cnt++;
        tick();
        total_cnt++; if ({o_read_complete, o_busy} !== 2'b00) $display("FAIL t1_k4_idle: got %b exp %b", {o_read_complete, o_busy}, 2'b00); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        apply_reset();
        i_re = 1'b1; i_we = 1'b1; i_wdata = 32'hDEAD_BEEF;
        tick(); i_re = 1'b0; i_we = 1'b0; i_wdata = 32'h0;
        total_cnt++; if ({o_mem_ren, o_mem_wen, o_mem_addr} !== {2'b10, 16'h0000}) $display("FAIL t2_read_first: got %b%b %h exp 10 0000", o_mem_ren, o_mem_wen, o_mem_addr); else pass_cnt++;
        tick(); tick();
        total_cnt++; if ({o_read_complete, o_write_complete, o_busy} !== 3'b101) $display("FAIL t2_rcpl: got %b exp %b", {o_read_complete, o_write_complete, o_busy}, 3'b101); else pass_cnt++;
        tick();
        total_cnt++; if ({o_mem_wen, o_mem_ren, o_mem_addr} !== {2'b10, 16'h8000}) $display("FAIL t2_write_next: got %b%b %h exp 10 8000", o_mem_wen, o_mem_ren, o_mem_addr); else pass_cnt++;
        total_cnt++; if (o_mem_wdata !== 32'hDEAD_BEEF) $display("FAIL t2_wdata: got %h exp %h", o_mem_wdata, 32'hDEAD_BEEF); else pass_cnt++;
        tick(); tick();
        total_cnt++; if ({o_write_complete, o_mem_wen} !== 2'b10) $display("FAIL t2_wcpl_3_later: got %b exp %b", {o_write_complete, o_mem_wen}, 2'b10); else pass_cnt++;
        tick();
        total_cnt++; if ({o_busy, o_err} !== 2'b00) $display("FAIL t2_end: got %b exp %b", {o_busy, o_err}, 2'b00); else pass_cnt++;
    endtask

    task automatic test_contention();
        int   n_acc = 0, n_wcpl = 0, rd_issued = 1, wr_issued = 1;
        logic prev_ren = 1'b0, prev_wen = 1'b0, rd_again = 1'b0, wr_again = 1'b0;
        apply_reset();
        i_re = 1'b1; i_we = 1'b1; i_wdata = 32'h1000_0000;
        for (int c = 0; c < 100; c++) begin
            tick();
            i_re = 1'b0; i_we = 1'b0;
            if (rd_again) begin i_re = 1'b1; rd_again = 1'b0; rd_issued++; end
            if (wr_again) begin i_we = 1'b1; i_wdata = 32'h1000_0000 + 32'(wr_issued); wr_again = 1'b0; wr_issued++; end
            if (o_read_complete && rd_issued < 4) rd_again = 1'b1;
            if (o_write_complete) begin n_wcpl++; if (wr_issued < 4) wr_again = 1'b1; end
            if (o_mem_ren && !prev_ren) begin
                total_cnt++; if ((n_acc % 2) != 0 || o_mem_addr !== 16'(n_acc / 2)) $display("FAIL t3_read_grant: access %0d got R addr %h exp %s addr %h", n_acc, o_mem_addr, ((n_acc % 2) == 0) ? "R" : "W", ((n_acc % 2) == 0) ? 16'(n_acc / 2) : 16'h8000 + 16'(n_acc / 2)); else pass_cnt++;
                n_acc++;
            end
            if (o_mem_wen && !prev_wen) begin
                total_cnt++; if ((n_acc % 2) != 1 || o_mem_addr !== 16'h8000 + 16'(n_acc / 2) || o_mem_wdata !== 32'h1000_0000 + 32'(n_acc / 2)) $display("FAIL t3_write_grant: access %0d got W addr %h data %h exp addr %h data %h", n_acc, o_mem_addr, o_mem_wdata, 16'h8000 + 16'(n_acc / 2), 32'h1000_0000 + 32'(n_acc / 2)); else pass_cnt++;
                n_acc++;
            end
            prev_ren = o_mem_ren; prev_wen = o_mem_wen;
            if (n_wcpl == 4) break;
        end
        i_re = 1'b0; i_we = 1'b0;
        total_cnt++; if (n_acc != 8 || n_wcpl != 4) $display("FAIL t3_access_count: got %0d accesses %0d writes exp 8 4", n_acc, n_wcpl); else pass_cnt++;
        tick();
        total_cnt++; if ({o_err, o_done, o_busy} !== 3'b010) $display("FAIL t3_end_flags: got %b exp %b", {o_err, o_done, o_busy}, 3'b010); else pass_cnt++;
    endtask

    task automatic test_done();
        logic got, saw_wen;
        apply_reset();
        for (int w = 0; w < 4; w++) begin
            i_we = 1'b1; i_wdata = 32'h0000_00A0 + 32'(w);
            tick(); i_we = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                if (o_write_complete) got = 1'b1; else tick();
            end
            total_cnt++; if (got !== 1'b1) $display("FAIL t4_wcpl_timeout: write %0d got %b exp %b", w, got, 1'b1); else pass_cnt++;
            tick();
            total_cnt++; if (o_done !== (w == 3)) $display("FAIL t4_done: after write %0d got %b exp %b", w, o_done, (w == 3)); else pass_cnt++;
        end
        i_we = 1'b1; i_wdata = 32'hFFFF_0005;
        tick(); i_we = 1'b0;
        saw_wen = o_mem_wen;
        for (int c = 0; c < 4; c++) begin tick(); saw_wen = saw_wen | o_mem_wen; end
        total_cnt++; if (saw_wen !== 1'b0) $display("FAIL t4_no_wen: got %b exp %b", saw_wen, 1'b0); else pass_cnt++;
        total_cnt++; if ({o_err, o_done, o_busy} !== 3'b110) $display("FAIL t4_err_done: got %b exp %b", {o_err, o_done, o_busy}, 3'b110); else pass_cnt++;
    endtask

    task automatic test_frame_start();
        apply_reset();
        i_mem_rdata = 32'h1111_2222; i_re = 1'b1;
        tick(); i_re = 1'b0;
        tick(); tick(); tick();
        i_mem_rdata = 32'h3333_4444; i_re = 1'b1;
        tick();
        total_cnt++; if ({o_mem_ren, o_mem_addr} !== {1'b1, 16'h0001}) $display("FAIL t5_second_addr: got %b %h exp 1 0001", o_mem_ren, o_mem_addr); else pass_cnt++;
        tick(); i_re = 1'b0;
        total_cnt++; if ({o_err, o_mem_ren} !== 2'b11) $display("FAIL t5_err_set: got %b exp %b", {o_err, o_mem_ren}, 2'b11); else pass_cnt++;
        i_frame_start = 1'b1;
        tick(); i_frame_start = 1'b0;
        total_cnt++; if ({o_mem_ren, o_read_complete, o_err, o_busy, o_done} !== 5'b0) $display("FAIL t5_cleared: got %b exp %b", {o_mem_ren, o_read_complete, o_err, o_busy, o_done}, 5'b0); else pass_cnt++;
        total_cnt++; if (o_rdata !== 32'h1111_2222) $display("FAIL t5_rdata_kept: got %h exp %h", o_rdata, 32'h1111_2222); else pass_cnt++;
        tick();
        total_cnt++; if (o_read_complete !== 1'b0) $display("FAIL t5_no_cpl: got %b exp %b", o_read_complete, 1'b0); else pass_cnt++;
        i_re = 1'b1;
        tick(); i_re = 1'b0;
        total_cnt++; if ({o_mem_ren, o_mem_addr} !== {1'b1, 16'h0000}) $display("FAIL t5_restart_addr: got %b %h exp 1 0000", o_mem_ren, o_mem_addr); else pass_cnt++;
        tick(); tick(); tick();
    endtask

    task automatic test_duplicate();
        int   n_rise = 0, n_cpl = 0;
        logic prev = 1'b0;
        apply_reset();
        i_re = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c == 1) i_re = 1'b0;
            if (o_mem_ren && !prev) n_rise++;
            if (o_read_complete) n_cpl++;
            prev = o_mem_ren;
        end
        total_cnt++; if (n_rise != 1) $display("FAIL t6_accesses: got %0d exp %0d", n_rise, 1); else pass_cnt++;
        total_cnt++; if (n_cpl != 1) $display("FAIL t6_cpl_pulses: got %0d exp %0d", n_cpl, 1); else pass_cnt++;
        total_cnt++; if ({o_err, o_busy} !== 2'b10) $display("FAIL t6_err: got %b exp %b", {o_err, o_busy}, 2'b10); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            i_re = 1'b1; i_mem_rdata = 32'hC0DE_0000 + 32'(r);
            tick(); i_re = 1'b0;
            total_cnt++; if ({o_mem_ren, o_mem_addr} !== {1'b1, 16'(r % 4)}) $display("FAIL t7_read_addr: read %0d got %b %h exp 1 %h", r, o_mem_ren, o_mem_addr, 16'(r % 4)); else pass_cnt++;
            tick(); tick();
            total_cnt++; if ({o_read_complete, o_rdata} !== {1'b1, 32'hC0DE_0000 + 32'(r)}) $display("FAIL t7_read_data: read %0d got %b %h exp 1 %h", r, o_read_complete, o_rdata, 32'hC0DE_0000 + 32'(r)); else pass_cnt++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_contention();
        test_done();
        test_frame_start();
        test_duplicate();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
